// File: rtl/mem_access.sv
// Memory stage: runs loads/stores on a req/ack bus and forwards writeback.
// Optional misalignment trapping is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
  input  logic                      reg_we_i,
  input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  input  logic [3:0]                mem_op_i,
  input  logic                      mem_we_i,
  input  logic                      csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
  input  logic [DATA_WIDTH-1:0]     exception_i,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [ADDR_WIDTH-1:0]     bus_addr_o,
  output logic [DATA_WIDTH-1:0]     bus_wdata_o,
  output logic [3:0]                bus_sel_o,
  input  logic                      bus_ack_i,
  input  logic                      bus_err_i,
  input  logic [DATA_WIDTH-1:0]     bus_rdata_i,
  output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
  output logic                      reg_we_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic [DATA_WIDTH-1:0]     exception_o,
  output logic                      stallreq_o
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]            cnt_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  is_load;
  logic                  is_store;
  logic [1:0]            sz;
  logic                  sext;
  logic [1:0]            off;
  logic                  mis;
  logic                  access;
  logic                  stall;
  logic [3:0]            sel;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] ld_val;

  // Decode op into direction, access size (0 byte, 1 half, 2 word) and signedness
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz       = 2'd0;
    sext     = 1'b0;
    unique case (mem_op_i)
      4'd1: begin is_load = 1'b1; sz = 2'd0; sext = 1'b1; end
      4'd2: begin is_load = 1'b1; sz = 2'd1; sext = 1'b1; end
      4'd3: begin is_load = 1'b1; sz = 2'd2; end
      4'd4: begin is_load = 1'b1; sz = 2'd0; end
      4'd5: begin is_load = 1'b1; sz = 2'd1; end
      4'd6: begin is_store = mem_we_i; sz = 2'd0; end
      4'd7: begin is_store = mem_we_i; sz = 2'd1; end
      4'd8: begin is_store = mem_we_i; sz = 2'd2; end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Byte offset used as-is; misaligned half/word accesses trap instead of issuing
  always_comb begin
    off = mem_addr_i[1:0];
    mis = (is_load | is_store) &
          (((sz == 2'd1) & mem_addr_i[0]) |
           ((sz == 2'd2) & (mem_addr_i[1:0] != 2'd0)));
  end
`else
  // Low offset bits are dropped so half/word accesses are always aligned
  always_comb begin
    mis = 1'b0;
    unique case (sz)
      2'd2:    off = 2'd0;
      2'd1:    off = {mem_addr_i[1], 1'b0};
      default: off = mem_addr_i[1:0];
    endcase
  end
`endif

  assign access = (is_load | is_store) & ~mis;

  // Byte enables by access size, shifted to the addressed lane
  always_comb begin
    unique case (sz)
      2'd2:    sel = 4'b1111;
      2'd1:    sel = 4'b0011 << off;
      default: sel = 4'b0001 << off;
    endcase
  end

  // FSM next-state and stall request
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_err_i || bus_ack_i || cnt_q == TMO)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bus request registers: load on issue, hold through BUSY, drop req on exit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_sel_o   <= 4'b0000;
    end else if (state_q == IDLE && access) begin
      bus_req_o   <= 1'b1;
      bus_we_o    <= is_store;
      bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
      bus_wdata_o <= mem_data_i << {off, 3'b000};
      bus_sel_o   <= sel;
    end else if (state_q == BUSY && state_d == DONE) begin
      bus_req_o   <= 1'b0;
    end
  end

  // Timeout counter, fault flag and read-data capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else if (state_q == DONE) begin
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else if (state_q == BUSY) begin
      if (bus_err_i || cnt_q == TMO) fault_q <= 1'b1;
      else if (bus_ack_i)            rdata_q <= bus_rdata_i;
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    word = rdata_q >> {off, 3'b000};
    unique case (sz)
      2'd0: ld_val = {{(DATA_WIDTH-8){sext & word[7]}}, word[7:0]};
      2'd1: ld_val = {{(DATA_WIDTH-16){sext & word[15]}}, word[15:0]};
      default: ld_val = word;
    endcase
  end

  // Writeback, CSR passthrough, exceptions and stall; all zero in reset
  always_comb begin
    reg_waddr_o = '0;
    reg_we_o    = 1'b0;
    reg_wdata_o = '0;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    exception_o = '0;
    stallreq_o  = 1'b0;
    if (rst_i) begin
      reg_waddr_o = reg_waddr_i;
      csr_we_o    = csr_we_i;
      csr_waddr_o = csr_waddr_i;
      csr_wdata_o = csr_wdata_i;
      stallreq_o  = stall;
      reg_wdata_o = (state_q == DONE && is_load) ? ld_val : reg_wdata_i;
      reg_we_o    = reg_we_i & ~fault_q & ~(mis & state_q == IDLE);
      exception_o = exception_i;
      if (state_q == DONE && fault_q) begin
        if (is_load)  exception_o[5] = 1'b1;
        if (is_store) exception_o[7] = 1'b1;
      end
      if (state_q == IDLE && mis) begin
        if (is_load)  exception_o[4] = 1'b1;
        if (is_store) exception_o[6] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
// Misalignment checks follow MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_op_i;
  logic        mem_we_i;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] exception_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic        bus_err_i;
  logic [31:0] bus_rdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] exception_o;
  logic        stallreq_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_access dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i),
    .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_op_i(mem_op_i), .mem_we_i(mem_we_i),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i),
    .csr_wdata_i(csr_wdata_i), .exception_i(exception_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i),
    .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o),
    .reg_wdata_o(reg_wdata_o), .csr_we_o(csr_we_o),
    .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .exception_o(exception_o), .stallreq_o(stallreq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Load with ack in the cycle after req; checks issue, bus and DONE data
  task automatic run_ld(input string tag, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] rd,
                        input logic [31:0] a_exp, input logic [3:0] s_exp,
                        input logic [31:0] exp);
    mem_op_i = op; mem_addr_i = addr; mem_we_i = 1'b0;
    reg_we_i = 1'b1; reg_wdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    chk({tag, "_stall_idle"}, 32'(stallreq_o), 32'd1);
    step();
    bus_ack_i = 1'b1; bus_rdata_i = rd;
    @(negedge clk_i);
    chk({tag, "_req"}, 32'(bus_req_o), 32'd1);
    chk({tag, "_addr"}, bus_addr_o, a_exp);
    chk({tag, "_sel"}, 32'(bus_sel_o), 32'(s_exp));
    chk({tag, "_we"}, 32'(bus_we_o), 32'd0);
    chk({tag, "_stall_busy"}, 32'(stallreq_o), 32'd1);
    step();
    bus_ack_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_stall_done"}, 32'(stallreq_o), 32'd0);
    chk({tag, "_req_done"}, 32'(bus_req_o), 32'd0);
    chk({tag, "_wdata"}, reg_wdata_o, exp);
    chk({tag, "_rwe"}, 32'(reg_we_o), 32'd1);
    step();
    mem_op_i = 4'd0;
  endtask

  initial begin
    int n;
    rst_i = 1'b0;
    reg_waddr_i = 5'd7; reg_we_i = 1'b0; reg_wdata_i = 32'h0;
    mem_addr_i = 32'h0; mem_data_i = 32'h0; mem_op_i = 4'd0;
    mem_we_i = 1'b0; csr_we_i = 1'b1; csr_waddr_i = 12'h305;
    csr_wdata_i = 32'hCAFE_0001; exception_i = 32'h1;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h0;

    @(negedge clk_i);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_csr_we", 32'(csr_we_o), 32'd0);
    chk("rst_exc", exception_o, 32'd0);
    chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
    step();
    rst_i = 1'b1;

    @(negedge clk_i);
    chk("nop_stall", 32'(stallreq_o), 32'd0);
    chk("nop_exc", exception_o, 32'h1);
    chk("nop_csr_addr", 32'(csr_waddr_o), 32'h305);
    chk("nop_csr_data", csr_wdata_o, 32'hCAFE_0001);
    chk("nop_waddr", 32'(reg_waddr_o), 32'd7);
    exception_i = 32'h0;

    mem_op_i = 4'd12;
    @(negedge clk_i);
    chk("op12_stall", 32'(stallreq_o), 32'd0);
    mem_op_i = 4'd8; mem_we_i = 1'b0;
    @(negedge clk_i);
    chk("sw_nowe_stall", 32'(stallreq_o), 32'd0);
    step();
    mem_op_i = 4'd0;

    run_ld("lw", 4'd3, 32'h100, 32'hDEAD_BEEF, 32'h100, 4'hF,
           32'hDEAD_BEEF);
    run_ld("lb", 4'd1, 32'h103, 32'h80FF_0000, 32'h100, 4'h8,
           32'hFFFF_FF80);
    run_ld("lbu", 4'd4, 32'h103, 32'h80FF_0000, 32'h100, 4'h8,
           32'h0000_0080);
    run_ld("lhu", 4'd5, 32'h102, 32'h80FF_0000, 32'h100, 4'hC,
           32'h0000_80FF);
    run_ld("lh", 4'd2, 32'h102, 32'h80FF_0000, 32'h100, 4'hC,
           32'hFFFF_80FF);

    // SB to 0x201 with reg_we_i low
    mem_op_i = 4'd6; mem_we_i = 1'b1; mem_addr_i = 32'h201;
    mem_data_i = 32'h0000_00AB; reg_we_i = 1'b0;
    reg_wdata_i = 32'h1234_0000;
    @(negedge clk_i);
    chk("sb_stall", 32'(stallreq_o), 32'd1);
    step();
    bus_ack_i = 1'b1;
    @(negedge clk_i);
    chk("sb_sel", 32'(bus_sel_o), 32'h2);
    chk("sb_wdata", bus_wdata_o, 32'h0000_AB00);
    chk("sb_we", 32'(bus_we_o), 32'd1);
    chk("sb_addr", bus_addr_o, 32'h200);
    step();
    bus_ack_i = 1'b0;
    @(negedge clk_i);
    chk("sb_rwe", 32'(reg_we_o), 32'd0);
    chk("sb_rwdata", reg_wdata_o, 32'h1234_0000);
    chk("sb_exc", exception_o, 32'd0);
    step();
    mem_op_i = 4'd0; mem_we_i = 1'b0;

    // Load with ack withheld until the timeout fires
    mem_op_i = 4'd3; mem_addr_i = 32'h300; reg_we_i = 1'b1;
    @(negedge clk_i);
    n = 0;
    while (stallreq_o === 1'b1 && n < 400) begin
      n++;
      @(negedge clk_i);
    end
    chk("to_cycles", 32'(n >= 256 && n <= 259), 32'd1);
    chk("to_exc5", 32'(exception_o[5]), 32'd1);
    chk("to_rwe", 32'(reg_we_o), 32'd0);
    step();
    mem_op_i = 4'd0;
    @(negedge clk_i);
    chk("to_clear", exception_o, 32'd0);

    // Error and ack together on a load
    mem_op_i = 4'd3; mem_addr_i = 32'h104;
    step();
    bus_ack_i = 1'b1; bus_err_i = 1'b1;
    step();
    bus_ack_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk_i);
    chk("err_exc5", 32'(exception_o[5]), 32'd1);
    chk("err_rwe", 32'(reg_we_o), 32'd0);
    step();
    mem_op_i = 4'd0;

    // Error on a word store
    mem_op_i = 4'd8; mem_we_i = 1'b1; mem_addr_i = 32'h108;
    mem_data_i = 32'h1234_5678;
    step();
    chk("sw_wdata", bus_wdata_o, 32'h1234_5678);
    bus_err_i = 1'b1;
    step();
    bus_err_i = 1'b0;
    @(negedge clk_i);
    chk("sw_err_exc7", 32'(exception_o[7]), 32'd1);
    chk("sw_err_exc5", 32'(exception_o[5]), 32'd0);
    step();
    mem_op_i = 4'd0; mem_we_i = 1'b0;

    // Reset asserted mid-transaction
    mem_op_i = 4'd3; mem_addr_i = 32'h100;
    step();
    chk("rb_req_busy", 32'(bus_req_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rb_req_rst", 32'(bus_req_o), 32'd0);
    chk("rb_stall_rst", 32'(stallreq_o), 32'd0);
    mem_op_i = 4'd0;
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rb_nop_stall", 32'(stallreq_o), 32'd0);
    step();
    run_ld("rb_lw", 4'd3, 32'h10C, 32'h0BAD_F00D, 32'h10C, 4'hF,
           32'h0BAD_F00D);

`ifdef MEM_MISALIGN_TRAP_EN
    mem_op_i = 4'd3; mem_addr_i = 32'h102; reg_we_i = 1'b1;
    @(negedge clk_i);
    chk("mis_stall", 32'(stallreq_o), 32'd0);
    chk("mis_exc4", 32'(exception_o[4]), 32'd1);
    chk("mis_rwe", 32'(reg_we_o), 32'd0);
    step();
    chk("mis_req", 32'(bus_req_o), 32'd0);
    mem_op_i = 4'd0;
`else
    run_ld("mis_lw", 4'd3, 32'h102, 32'h1122_3344, 32'h100, 4'hF,
           32'h1122_3344);
    chk("mis_exc", exception_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
